min4_stream_window: RTL and testbench

Sequential front-end for the four-input unsigned minimum stage. Accepts a stream of samples over a valid/ready handshake and packs them into four-lane groups. Each completed group goes through the four-way minimum comparator. The result is held in an output register with its own valid/ready handshake, so a new group can be collected while the previous result waits.

---
 rtl/min4_pkg.sv | 16 +
 rtl/min4_stream_window_if.sv | 32 +++
 rtl/min4_tree.sv | 41 ++++
 rtl/min4_stream_window.sv | 132 +++++++++++++
 tb/tb_min4_stream_window.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/min4_pkg.sv
// Shared definitions for the min4 stream window slice.
//   LANES      : number of lanes collected per group
//   lane_idx_t : lane index type (also the fill counter type)
//   pad_word() : all-ones padding word for a given width (WIDTH <= 64)
package min4_pkg;

    localparam int LANES = 4;

    typedef logic [1:0] lane_idx_t;

    // All-ones value in the low 'width' bits; callers truncate to their width.
    function automatic logic [63:0] pad_word(input int unsigned width);
        pad_word = {64{1'b1}} >> (32'd64 - width);
    endfunction

endpackage

// File: rtl/min4_stream_window_if.sv
// Handshake bundle for min4_stream_window.
//   in_valid/in_ready/in_data/flush : sample stream into the block
//   out_valid/out_ready/out_min     : result stream out of the block
//   out_idx                         : winning lane, only with MIN4_ARGIDX_EN
// Modports: master = producer/consumer side (testbench), slave = the block.
interface min4_stream_window_if #(
    parameter int WIDTH = 8
);
    import min4_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
`ifdef MIN4_ARGIDX_EN
    lane_idx_t        out_idx;

    modport master (output in_valid, in_data, flush, out_ready,
                    input  in_ready, out_valid, out_min, out_idx);
    modport slave  (input  in_valid, in_data, flush, out_ready,
                    output in_ready, out_valid, out_min, out_idx);
`else
    modport master (output in_valid, in_data, flush, out_ready,
                    input  in_ready, out_valid, out_min);
    modport slave  (input  in_valid, in_data, flush, out_ready,
                    output in_ready, out_valid, out_min);
`endif

endinterface

// File: rtl/min4_tree.sv
// Purely combinational four-lane unsigned minimum.
//   lanes   : the four candidate values
//   min_val : smallest value (unsigned)
//   min_idx : lane of the smallest value, lowest lane wins ties
//             (port present only with MIN4_ARGIDX_EN)
module min4_tree
    import min4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] lanes [LANES],
`ifdef MIN4_ARGIDX_EN
    output lane_idx_t        min_idx,
`endif
    output logic [WIDTH-1:0] min_val
);

    logic [WIDTH-1:0] min01_s;
    logic [WIDTH-1:0] min23_s;

    // Two pairwise stages; strict '<' keeps the lower lane on ties, and the
    // 0/1 pair always carries lower indices than the 2/3 pair.
    always_comb begin
        min01_s = (lanes[1] < lanes[0]) ? lanes[1] : lanes[0];
        min23_s = (lanes[3] < lanes[2]) ? lanes[3] : lanes[2];
        min_val = (min23_s < min01_s) ? min23_s : min01_s;
    end

`ifdef MIN4_ARGIDX_EN
    lane_idx_t idx01_s;
    lane_idx_t idx23_s;

    // Index path mirrors the value path with the same tie-break.
    always_comb begin
        idx01_s = (lanes[1] < lanes[0]) ? 2'd1 : 2'd0;
        idx23_s = (lanes[3] < lanes[2]) ? 2'd3 : 2'd2;
        min_idx = (min23_s < min01_s) ? idx23_s : idx01_s;
    end
`endif

endmodule

// File: rtl/min4_stream_window.sv
// Packs a sample stream into four-lane groups and registers the unsigned
// minimum of each closed group behind its own valid/ready handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : min4_stream_window_if.slave (sample in, result out)
// Optional feature: define MIN4_ARGIDX_EN to add out_idx (winning lane).
module min4_stream_window
    import min4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    min4_stream_window_if.slave         bus
);

    localparam logic [WIDTH-1:0] PAD = WIDTH'(pad_word(WIDTH));

    logic [WIDTH-1:0] lanes_r [LANES];
    logic [WIDTH-1:0] cand_s  [LANES];
    lane_idx_t        count_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_min_r;
    logic [WIDTH-1:0] tree_min_s;
    logic             out_free_s;
    logic             closing_next_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             close_s;

    // Handshake decode: a close needs a free output register, so only the
    // group-completing accept (or a pending flush) can stall the input.
    always_comb begin
        out_free_s     = !out_valid_r || bus.out_ready;
        closing_next_s = (count_r == 2'd3) ||
                         (bus.flush && (bus.in_valid || (count_r != 2'd0)));
        if (reset) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = !(closing_next_s && !out_free_s);
        end
        accept_s = bus.in_valid && in_ready_s;
        if (accept_s) begin
            close_s = (count_r == 2'd3) || bus.flush;
        end else begin
            close_s = bus.flush && (count_r != 2'd0) && out_free_s;
        end
    end

    // Comparator candidates: the sample accepted this cycle bypasses its lane
    // register so a closing accept is included in the result.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (accept_s && (count_r == lane_idx_t'(i))) begin
                cand_s[i] = bus.in_data;
            end else begin
                cand_s[i] = lanes_r[i];
            end
        end
    end

`ifdef MIN4_ARGIDX_EN
    lane_idx_t tree_idx_s;
    lane_idx_t out_idx_r;

    min4_tree #(.WIDTH(WIDTH)) u_tree (
        .lanes   (cand_s),
        .min_idx (tree_idx_s),
        .min_val (tree_min_s)
    );

    // Winning-lane register, loaded alongside out_min.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx_r <= 2'd0;
        end else if (close_s) begin
            out_idx_r <= tree_idx_s;
        end else begin
            out_idx_r <= out_idx_r;
        end
    end

    assign bus.out_idx = out_idx_r;
`else
    min4_tree #(.WIDTH(WIDTH)) u_tree (
        .lanes   (cand_s),
        .min_val (tree_min_s)
    );
`endif

    // Lane file and fill count; every close re-pads all lanes so unwritten
    // lanes of the next group can never win.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 2'd0;
            for (int i = 0; i < LANES; i++) begin
                lanes_r[i] <= PAD;
            end
        end else if (close_s) begin
            count_r <= 2'd0;
            for (int i = 0; i < LANES; i++) begin
                lanes_r[i] <= PAD;
            end
        end else if (accept_s) begin
            lanes_r[count_r] <= bus.in_data;
            count_r          <= count_r + 2'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Result register: a close loads (even while the old result drains);
    // otherwise valid clears on transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_min_r   <= '0;
        end else if (close_s) begin
            out_valid_r <= 1'b1;
            out_min_r   <= tree_min_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_min   = out_min_r;

endmodule

// File: tb/tb_min4_stream_window.sv
module tb_min4_stream_window;

    typedef struct packed {
        logic [7:0] m;
        logic [1:0] i;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    min4_stream_window_if #(.WIDTH(8)) sif ();

    min4_stream_window #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one sample, wait (bounded) until it is accepted.
    task automatic send(input logic [7:0] d, input logic f);
        bit ok;
        ok = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.flush    = f;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sif.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: data %0h never accepted", d);
        end
        @(posedge clk);
        #1;
        sif.flush = 1'b0;
    endtask

    task automatic idle(input int n, input logic f);
        sif.in_valid = 1'b0;
        sif.flush    = f;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        sif.flush = 1'b0;
    endtask

    task automatic push(input logic [7:0] m, input logic [1:0] i);
        exp_t e;
        e.m = m;
        e.i = i;
        sb.push_back(e);
    endtask

    // Monitor: every result transfer is compared against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0 && sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", sif.out_min);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_min", 32'(sif.out_min), 32'(e.m));
`ifdef MIN4_ARGIDX_EN
                check("out_idx", 32'(sif.out_idx), 32'(e.i));
`endif
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        sif.in_valid  = 1'b0;
        sif.in_data   = 8'd0;
        sif.flush     = 1'b0;
        sif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_out_min", 32'(sif.out_min), 32'd0);
        check("rst_in_ready", 32'(sif.in_ready), 32'd1);
`ifdef MIN4_ARGIDX_EN
        check("rst_out_idx", 32'(sif.out_idx), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic group with a tie between lanes 1 and 3.
        send(8'd9, 1'b0);
        send(8'd4, 1'b0);
        send(8'd7, 1'b0);
        push(8'd4, 2'd1);
        send(8'd4, 1'b0);
        sif.in_valid = 1'b0;
        check("latency_valid", 32'(sif.out_valid), 32'd1);
        idle(2, 1'b0);

        // Flush without a sample after two lanes.
        send(8'd5, 1'b0);
        send(8'd3, 1'b0);
        push(8'd3, 2'd1);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Flush carried with an accepted sample; padded lanes must lose.
        send(8'd8, 1'b0);
        push(8'd6, 2'd1);
        send(8'd6, 1'b1);
        idle(2, 1'b0);

        // Flush on an empty group is ignored (monitor flags any result).
        idle(2, 1'b1);
        idle(2, 1'b0);

        // All lanes 0xFF, then all lanes equal.
        push(8'hFF, 2'd0);
        for (int k = 0; k < 4; k++) send(8'hFF, 1'b0);
        push(8'd2, 2'd0);
        for (int k = 0; k < 4; k++) send(8'd2, 1'b0);
        idle(2, 1'b0);

        // Back-to-back with a stalled consumer.
        sif.out_ready = 1'b0;
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        push(8'd10, 2'd0);
        send(8'd40, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        sif.in_valid = 1'b1;
        sif.in_data  = 8'd0;
        @(negedge clk);
        check("stall_in_ready", 32'(sif.in_ready), 32'd0);
        check("held_min", 32'(sif.out_min), 32'd10);
        @(posedge clk);
        #1;
        sif.out_ready = 1'b1;
        push(8'd0, 2'd3);
        @(negedge clk);
        check("drain_in_ready", 32'(sif.in_ready), 32'd1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        check("swap_valid", 32'(sif.out_valid), 32'd1);
        check("swap_min", 32'(sif.out_min), 32'd0);
        idle(2, 1'b0);

        // Flush stall while the output register is full.
        sif.out_ready = 1'b0;
        push(8'd50, 2'd0);
        send(8'd50, 1'b0);
        send(8'd60, 1'b0);
        send(8'd70, 1'b0);
        send(8'd80, 1'b0);
        send(8'd9, 1'b0);
        sif.in_valid = 1'b0;
        sif.flush    = 1'b1;
        @(negedge clk);
        check("flush_stall_ready", 32'(sif.in_ready), 32'd0);
        @(negedge clk);
        check("flush_stall_min", 32'(sif.out_min), 32'd50);
        @(posedge clk);
        #1;
        sif.out_ready = 1'b1;
        push(8'd9, 2'd0);
        @(posedge clk);
        #1;
        sif.flush = 1'b0;
        check("flush_load_min", 32'(sif.out_min), 32'd9);
        idle(3, 1'b0);

        // Reset mid-group discards the partial group.
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        sif.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("in_reset_ready", 32'(sif.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post_reset_valid", 32'(sif.out_valid), 32'd0);
        send(8'd6, 1'b0);
        send(8'd6, 1'b0);
        send(8'd6, 1'b0);
        push(8'd5, 2'd3);
        send(8'd5, 1'b0);
        idle(5, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
